// File: rtl/can_rx_fifo.sv
// ============================================================================
// Module   : can_rx_fifo
// Brief    : CAN receive frame FIFO with acceptance filters and register port.
//            Optional per-frame timestamps via CAN_RX_FIFO_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int NFILT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [28:0] rx_id,
    input  logic        rx_ext,
    input  logic        rx_rtr,
    input  logic [3:0]  rx_dlc,
    input  logic [63:0] rx_data,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int         c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_depth = 4'(DEPTH);

    typedef struct packed {
        logic        ext;
        logic        rtr;
        logic [1:0]  hit;
        logic [3:0]  dlc;
        logic [28:0] id;
        logic [63:0] data;
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
        logic [15:0] ts;
`endif
    } entry_t;

    logic [1:0]       r_irq_en;
    logic [NFILT-1:0] r_filt_en;
    logic [31:0]      r_code [0:NFILT-1];
    logic [31:0]      r_mask [0:NFILT-1];
    logic [c_aw-1:0]  r_head;
    logic [c_aw-1:0]  r_tail;
    logic [3:0]       r_count;
    logic             r_ovf;
    logic [7:0]       r_drop;
    entry_t           r_mem [0:DEPTH-1];
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
    logic [15:0]      r_ts;
`endif

    logic             w_wr;
    logic             w_rd;
    logic             w_flush;
    logic             w_pop_req;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic [NFILT-1:0] w_hit;
    logic             w_accept;
    logic [1:0]       w_hit_idx;
    entry_t           w_new;
    entry_t           w_head;
    logic [31:0]      w_ctrl;
    logic [31:0]      w_reg;

    assign w_wr      = (data_write_n == 2'b10);
    assign w_rd      = (data_read_n == 2'b10);
    assign w_flush   = w_wr && (address == 6'h00) && data_in[31];
    assign w_pop_req = w_wr && (address == 6'h1C);
    assign w_empty   = (r_count == 4'd0);
    assign w_full    = (r_count == c_depth);

    // Flush overrides both queue operations issued in the same cycle.
    assign w_pop      = w_pop_req && !w_empty && !w_flush;
    assign w_push_req = rx_valid && w_accept && !w_flush;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    generate
        for (genvar k = 0; k < NFILT; k++) begin : g_filt
            assign w_hit[k] = r_filt_en[k]
                && (((rx_id ^ r_code[k][28:0]) & r_mask[k][28:0]) == 29'd0)
                && (!r_mask[k][31] || (rx_ext == r_code[k][31]));
        end
    endgenerate

    assign w_accept = (r_filt_en == '0) || (|w_hit);

    always_comb begin
        w_hit_idx = 2'd0;
        for (int k = NFILT - 1; k >= 0; k--) begin
            if (w_hit[k]) w_hit_idx = 2'(k);
        end
    end

    always_comb begin
        w_new      = '0;
        w_new.ext  = rx_ext;
        w_new.rtr  = rx_rtr;
        w_new.hit  = w_hit_idx;
        w_new.dlc  = rx_dlc;
        w_new.id   = rx_id;
        w_new.data = rx_data;
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
        w_new.ts   = r_ts;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en  <= 2'b00;
            r_filt_en <= '0;
            for (int k = 0; k < NFILT; k++) begin
                r_code[k] <= 32'd0;
                r_mask[k] <= 32'd0;
            end
        end else begin
            if (w_wr && (address == 6'h00)) begin
                r_irq_en  <= data_in[1:0];
                r_filt_en <= data_in[8 +: NFILT];
            end
            for (int k = 0; k < NFILT; k++) begin
                if (w_wr && (address == 6'(32 + 8 * k))) r_code[k] <= data_in;
                if (w_wr && (address == 6'(36 + 8 * k))) r_mask[k] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 4'd0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 4'd0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 4'd1;
            else if (w_pop && !w_push) r_count <= r_count - 4'd1;
        end
    end

    // A status clear takes priority over a drop landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_drop <= 8'd0;
        end else if (w_wr && (address == 6'h04) && data_in[6]) begin
            r_ovf  <= 1'b0;
            r_drop <= 8'd0;
        end else if (w_drop) begin
            r_ovf  <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= w_new;
    end

`ifdef CAN_RX_FIFO_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ts <= 16'd0;
        else        r_ts <= r_ts + 16'd1;
    end
`endif

    assign w_head = w_empty ? '0 : r_mem[r_head];

    always_comb begin
        w_ctrl             = 32'd0;
        w_ctrl[1:0]        = r_irq_en;
        w_ctrl[8 +: NFILT] = r_filt_en;
    end

    always_comb begin
        w_reg = 32'd0;
        case (address)
            6'h00: w_reg = w_ctrl;
            6'h04: w_reg = {8'd0, r_drop, 9'd0, r_ovf, w_full, w_empty, r_count};
            6'h08: w_reg = {w_head.ext, w_head.rtr, 1'b0, w_head.id};
            6'h0C: w_reg = {22'd0, w_head.hit, 4'd0, w_head.dlc};
            6'h10: w_reg = {w_head.data[39:32], w_head.data[47:40],
                            w_head.data[55:48], w_head.data[63:56]};
            6'h14: w_reg = {w_head.data[7:0],   w_head.data[15:8],
                            w_head.data[23:16], w_head.data[31:24]};
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
            6'h18: w_reg = {16'd0, w_head.ts};
`endif
            default: w_reg = 32'd0;
        endcase
        for (int k = 0; k < NFILT; k++) begin
            if (address == 6'(32 + 8 * k)) w_reg = r_code[k];
            if (address == 6'(36 + 8 * k)) w_reg = r_mask[k];
        end
    end

    assign data_out       = w_rd ? w_reg : 32'd0;
    assign data_ready     = 1'b1;
    assign user_interrupt = (r_irq_en[0] && !w_empty) || (r_irq_en[1] && r_ovf);

endmodule

`default_nettype wire

// File: tb/tb_can_rx_fifo.sv
// ============================================================================
// Module   : tb_can_rx_fifo
// Brief    : Self-checking bench for can_rx_fifo (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_can_rx_fifo;

    localparam int DEPTH = 4;
    localparam int NFILT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [28:0] rx_id;
    logic        rx_ext;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    can_rx_fifo #(.DEPTH(DEPTH), .NFILT(NFILT)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_id(rx_id),
        .rx_ext(rx_ext), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc), .rx_data(rx_data),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] id_w;
        logic [31:0] dlc_w;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    typedef struct {
        logic [28:0] id;
        logic        ext;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        acc;
        logic [1:0]  hit;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[7];
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_drop = 0;
    logic        exp_ovf  = 1'b0;
    logic [31:0] rd;
    logic [31:0] ts_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        address = a; data_in = d; data_write_n = 2'b10;
        tick();
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        address = a; data_read_n = 2'b10;
        #1;
        d = data_out;
        data_read_n = 2'b11;
    endtask

    function automatic exp_t mk(input logic [28:0] id, input logic ext, input logic rtr,
                                input logic [3:0] dlc, input logic [63:0] data,
                                input logic [1:0] hit);
        exp_t e;
        e.id_w  = {ext, rtr, 1'b0, id};
        e.dlc_w = {22'd0, hit, 4'd0, dlc};
        e.d0    = {data[39:32], data[47:40], data[55:48], data[63:56]};
        e.d1    = {data[7:0], data[15:8], data[23:16], data[31:24]};
        return e;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [3:0] cnt;
        cnt = 4'(sb.size());
        return {8'd0, 8'(exp_drop), 9'd0, exp_ovf, (sb.size() == DEPTH), (sb.size() == 0), cnt};
    endfunction

    // Drives one rx_valid pulse (optionally with a POP) and updates the model.
    task automatic send(input logic [28:0] id, input logic ext, input logic rtr,
                        input logic [3:0] dlc, input logic [63:0] data,
                        input logic acc, input logic [1:0] hit, input logic pop);
        logic full_before;
        logic did_pop;
        rx_id = id; rx_ext = ext; rx_rtr = rtr; rx_dlc = dlc; rx_data = data;
        rx_valid = 1'b1;
        if (pop) begin
            address = 6'h1C; data_in = 32'd0; data_write_n = 2'b10;
        end
        tick();
        rx_valid = 1'b0; data_write_n = 2'b11;
        full_before = (sb.size() == DEPTH);
        did_pop = pop && (sb.size() > 0);
        if (did_pop) void'(sb.pop_front());
        if (acc) begin
            if (full_before && !did_pop) begin
                exp_ovf = 1'b1;
                if (exp_drop < 255) exp_drop++;
            end else begin
                sb.push_back(mk(id, ext, rtr, dlc, data, hit));
            end
        end
    endtask

    task automatic check_head(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s: scoreboard empty, got nothing expected a frame", name);
        end else begin
            e = sb.pop_front();
            bus_read(6'h08, rd); check({name, "_id"},   rd, e.id_w);
            bus_read(6'h0C, rd); check({name, "_dlc"},  rd, e.dlc_w);
            bus_read(6'h10, rd); check({name, "_d0"},   rd, e.d0);
            bus_read(6'h14, rd); check({name, "_d1"},   rd, e.d1);
            bus_write(6'h1C, 32'd0);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < DEPTH && sb.size() > 0; i++) check_head(name);
        bus_read(6'h04, rd); check({name, "_status"}, rd, exp_status());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_id = '0; rx_ext = 1'b0; rx_rtr = 1'b0;
        rx_dlc = '0; rx_data = '0; address = '0; data_in = '0;
        data_write_n = 2'b11; data_read_n = 2'b11;

        //           id             ext   rtr   dlc   data                     acc   hit
        vt[0] = '{29'h105,       1'b0, 1'b0, 4'd1, 64'h1100000000000000, 1'b0, 2'd0};
        vt[1] = '{29'h105,       1'b1, 1'b0, 4'd2, 64'h2122000000000000, 1'b1, 2'd0};
        vt[2] = '{29'h100,       1'b0, 1'b1, 4'd0, 64'h0,                1'b1, 2'd1};
        vt[3] = '{29'h100,       1'b1, 1'b0, 4'd8, 64'h0123456789ABCDEF, 1'b1, 2'd0};
        vt[4] = '{29'h1FF,       1'b1, 1'b0, 4'd3, 64'h5555550000000000, 1'b0, 2'd0};
        vt[5] = '{29'h08000105,  1'b1, 1'b0, 4'd8, 64'hFEDCBA9876543210, 1'b1, 2'd0};
        vt[6] = '{29'h200,       1'b0, 1'b0, 4'd4, 64'h9988776600000000, 1'b0, 2'd0};

        repeat (2) @(posedge clk);
        #1;
        bus_read(6'h04, rd); check("reset_status", rd, 32'h00000010);
        bus_read(6'h00, rd); check("reset_ctrl", rd, 32'h0);
        check("reset_irq", {31'd0, user_interrupt}, 32'd0);
        check("data_ready", {31'd0, data_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Single frame, no filters.
        send(29'h123, 1'b0, 1'b0, 4'd2, 64'hAABBCCDDEEFF0011, 1'b1, 2'd0, 1'b0);
        bus_read(6'h04, rd); check("single_status", rd, exp_status());
        bus_read(6'h10, rd); check("single_d0_lo", {16'd0, rd[15:0]}, 32'h0000BBAA);
        check_head("single");
        bus_read(6'h04, rd); check("single_empty", rd, 32'h00000010);
        bus_read(6'h08, rd); check("empty_head_id", rd, 32'h0);

        // Acceptance filters, table driven.
        bus_write(6'h20, 32'h80000100);
        bus_write(6'h24, 32'h800007F0);
        bus_write(6'h28, 32'h00000100);
        bus_write(6'h2C, 32'h000007FF);
        bus_read(6'h20, rd); check("code0_rb", rd, 32'h80000100);
        bus_read(6'h2C, rd); check("mask1_rb", rd, 32'h000007FF);
        bus_write(6'h00, 32'h00000300);
        for (int i = 0; i < 7; i++) begin
            send(vt[i].id, vt[i].ext, vt[i].rtr, vt[i].dlc, vt[i].data,
                 vt[i].acc, vt[i].hit, 1'b0);
            bus_read(6'h04, rd); check($sformatf("filt_status_%0d", i), rd, exp_status());
        end
        drain("filt");
        bus_write(6'h00, 32'h0);

        // Overflow with DEPTH frames plus one.
        for (int i = 0; i < 5; i++)
            send(29'(32'h10 + i), 1'b0, 1'b0, 4'(i), {$urandom(), $urandom()}, 1'b1, 2'd0, 1'b0);
        bus_read(6'h04, rd); check("ovf_status", rd, exp_status());
        check("ovf_status_const", rd, 32'h00010064);
        bus_read(6'h08, rd); check("ovf_head_frame1", rd, 32'h00000010);

        // Push and pop together while full.
        send(29'h77, 1'b1, 1'b0, 4'd8, {$urandom(), $urandom()}, 1'b1, 2'd0, 1'b1);
        bus_read(6'h04, rd); check("pushpop_status", rd, exp_status());
        drain("pushpop");
        bus_write(6'h1C, 32'd0);
        bus_read(6'h04, rd); check("pop_empty_status", rd, exp_status());

        // Drop counter saturation and clear.
        for (int i = 0; i < 300; i++)
            send(29'(i), 1'b0, 1'b0, 4'd1, 64'h0, 1'b1, 2'd0, 1'b0);
        bus_read(6'h04, rd); check("drop_sat", rd, exp_status());
        bus_write(6'h04, 32'h00000040);
        exp_ovf = 1'b0; exp_drop = 0;
        bus_read(6'h04, rd); check("ovf_clear", rd, exp_status());
        bus_write(6'h00, 32'h80000000);
        sb.delete();
        bus_read(6'h04, rd); check("flush_status", rd, 32'h00000010);

        // Nonempty interrupt and flush colliding with a push.
        bus_write(6'h00, 32'h00000001);
        check("irq_idle", {31'd0, user_interrupt}, 32'd0);
        send(29'h55, 1'b0, 1'b0, 4'd1, 64'h0, 1'b1, 2'd0, 1'b0);
        check("irq_nonempty", {31'd0, user_interrupt}, 32'd1);
        rx_id = 29'h66; rx_valid = 1'b1;
        address = 6'h00; data_in = 32'h80000001; data_write_n = 2'b10;
        tick();
        rx_valid = 1'b0; data_write_n = 2'b11;
        sb.delete();
        bus_read(6'h04, rd); check("flush_push_status", rd, 32'h00000010);
        check("flush_irq", {31'd0, user_interrupt}, 32'd0);
        bus_read(6'h00, rd); check("ctrl_flush_rd0", rd, 32'h00000001);

        // Overflow interrupt.
        bus_write(6'h00, 32'h00000002);
        for (int i = 0; i < 5; i++)
            send(29'(i), 1'b0, 1'b0, 4'd0, 64'h0, 1'b1, 2'd0, 1'b0);
        check("irq_ovf", {31'd0, user_interrupt}, 32'd1);
        bus_write(6'h04, 32'h00000040);
        exp_ovf = 1'b0; exp_drop = 0;
        check("irq_ovf_clear", {31'd0, user_interrupt}, 32'd0);
        bus_write(6'h00, 32'h80000000);
        sb.delete();

        // Non-32-bit accesses are ignored.
        address = 6'h00; data_in = 32'h00000003; data_write_n = 2'b00;
        tick();
        data_write_n = 2'b11;
        bus_read(6'h00, rd); check("narrow_write", rd, 32'h0);
        send(29'h42, 1'b0, 1'b0, 4'd1, 64'h0, 1'b1, 2'd0, 1'b0);
        address = 6'h04; data_read_n = 2'b01;
        #1;
        check("narrow_read", data_out, 32'h0);
        data_read_n = 2'b11;
        bus_write(6'h00, 32'h80000000);
        sb.delete();

`ifdef CAN_RX_FIFO_TIMESTAMP_EN
        send(29'h1, 1'b0, 1'b0, 4'd0, 64'h0, 1'b1, 2'd0, 1'b0);
        repeat (99) tick();
        send(29'h2, 1'b0, 1'b0, 4'd0, 64'h0, 1'b1, 2'd0, 1'b0);
        bus_read(6'h18, ts_a);
        check_head("ts_a");
        bus_read(6'h18, rd);
        check("ts_delta", {16'd0, 16'(rd[15:0] - ts_a[15:0])}, 32'd100);
        check_head("ts_b");
`else
        send(29'h1, 1'b0, 1'b0, 4'd0, 64'h0, 1'b1, 2'd0, 1'b0);
        bus_read(6'h18, rd); check("ts_zero", rd, 32'h0);
        check_head("ts_none");
`endif

        // Asynchronous reset during an in-flight push.
        bus_write(6'h20, 32'h12345678);
        bus_write(6'h00, 32'h00000001);
        send(29'h9, 1'b0, 1'b0, 4'd0, 64'h0, 1'b1, 2'd0, 1'b0);
        rx_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        bus_read(6'h04, rd); check("arst_status", rd, 32'h00000010);
        bus_read(6'h20, rd); check("arst_code0", rd, 32'h0);
        check("arst_irq", {31'd0, user_interrupt}, 32'd0);
        tick();
        rx_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        sb.delete(); exp_ovf = 1'b0; exp_drop = 0;
        bus_read(6'h04, rd); check("post_rst_status", rd, exp_status());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
